round_timer_ctrl: RTL
=====================

ROUND_TIMER_CTRL -- requirements
Module: round_timer_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 65_000_000: clk cycles per game second.
REQ-002 Parameter ROUND_SEC, default 60: round length in seconds; legal range 1..255.
REQ-003 Parameter WARN_SEC, default 10: warn threshold in seconds; legal range 0..ROUND_SEC.
REQ-004 Parameter RETURN_SEC, default 15: seconds in time-out before auto return to title; legal range 1..255.
REQ-005 clk  in  1  sole clock; all logic on the rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 wait_for_start  in  1  high while the game state machine is in StartGame; load request.
REQ-008 game_on  in  1  high during InGame or TimeOut.
REQ-009 time_out  in  1  high during TimeOut.
REQ-010 pause  in  1  level; freezes counting while high.
REQ-011 timer  out  1  round expired; drives the state machine Timer input.
REQ-012 seconds_left  out  8  remaining seconds; unsigned.
REQ-013 warn  out  1  round in final WARN_SEC seconds.
REQ-014 tick  out  1  one-cycle pulse per elapsed counted second.
REQ-015 return_title  out  1  one-cycle pulse requesting return to title; ORed with START outside this block.

Function
REQ-016 FSM states SHALL be IDLE, LOAD, RUN, EXPIRED and RET_WAIT; all outputs registered.
REQ-017 IDLE: seconds_left=0, timer=0; wait_for_start=1 -> LOAD.
REQ-018 LOAD: seconds_left<=ROUND_SEC, prescaler<=0; next cycle -> RUN unconditionally.
REQ-019 RUN: prescaler increments by 1 each cycle when pause=0; when pause=1, prescaler, seconds_left and tick freeze.
REQ-020 RUN: when prescaler==CLK_DIV-1 and pause=0 -> prescaler<=0, tick=1 for that one cycle, seconds_left decrements by 1.
REQ-021 RUN: the decrement that reaches 0 -> EXPIRED, with timer=1 registered on the same edge that sets seconds_left=0.
REQ-022 EXPIRED: timer held at 1 until time_out=1; then -> RET_WAIT with timer<=0, seconds_left<=RETURN_SEC, prescaler<=0.
REQ-023 RET_WAIT: counts like RUN, including tick and pause behaviour; the decrement reaching 0 -> return_title=1 for one cycle and -> IDLE.
REQ-024 RET_WAIT with time_out=0 (player left via START) -> IDLE with no return_title pulse.
REQ-025 wait_for_start=1 in any state other than LOAD -> LOAD; this has priority over all other transitions (restart mid-round or from time-out).
REQ-026 RUN with game_on=0 -> IDLE (abort); seconds_left<=0, no timer pulse.
REQ-027 warn=1 exactly when state==RUN and 0<seconds_left<=WARN_SEC; WARN_SEC=0 keeps warn=0.
REQ-028 Prescaler width SHALL be $clog2(CLK_DIV); seconds_left SHALL never wrap below 0 or exceed 255.
REQ-029 A tick and a state exit on the same edge: the exit wins and no further decrement occurs.

Reset
REQ-030 rst=0 SHALL force IDLE, prescaler=0, seconds_left=0, timer=0, warn=0, tick=0 and return_title=0 immediately, independent of clk.
REQ-031 Reset released mid-round SHALL resume in IDLE; counting restarts only on a new wait_for_start.

Verification (CLK_DIV=4, ROUND_SEC=3, WARN_SEC=2, RETURN_SEC=2)
REQ-032 1-cycle wait_for_start pulse, game_on=1 -> seconds_left=3, then 2/1/0 at 4-cycle intervals; tick pulses 3 times; warn=1 at 2 and 1; timer=1 on the edge seconds_left=0.
REQ-033 Pause held 5 cycles mid-second -> that second's decrement is delayed by exactly 5 cycles.
REQ-034 Expire, then time_out=1 -> timer=0, seconds_left=2; 8 cycles later return_title pulses 1 cycle, state IDLE.
REQ-035 In RET_WAIT, time_out drops -> IDLE, no return_title; wait_for_start during EXPIRED -> seconds_left=3, timer=0.
REQ-036 rst asserted mid-RUN at seconds_left=2 -> all outputs 0 before the next clk edge; after release, no ticks until wait_for_start.
REQ-037 game_on drops in RUN -> IDLE next edge, seconds_left=0, timer stays 0.

Source files
------------

// File: rtl/round_timer_ctrl.sv
// Round timer controller: counts a game round down in seconds, flags the
// final warning window, holds an expired indication until the game enters
// time-out, then counts the time-out period and requests a return to title.
module round_timer_ctrl #(
  parameter int CLK_DIV    = 65_000_000,
  parameter int ROUND_SEC  = 60,
  parameter int WARN_SEC   = 10,
  parameter int RETURN_SEC = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wait_for_start,
  input  logic       game_on,
  input  logic       time_out,
  input  logic       pause,
  output logic       timer,
  output logic [7:0] seconds_left,
  output logic       warn,
  output logic       tick,
  output logic       return_title
);

  // A divider of 1 still needs a one-bit prescaler to keep the vector legal.
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX   = PW'(CLK_DIV - 1);
  localparam logic [7:0]    ROUND_LD  = 8'(ROUND_SEC);
  localparam logic [7:0]    RETURN_LD = 8'(RETURN_SEC);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    EXPIRED,
    RET_WAIT
  } state_t;

  state_t          state;
  logic [PW-1:0]   prescaler;
  logic [7:0]      sec_dec;
  logic            sec_done;

  // Decrement that saturates at zero so the seconds count can never wrap.
  function automatic logic [7:0] sat_dec(input logic [7:0] s);
    return (s == 8'd0) ? 8'd0 : s - 8'd1;
  endfunction

  // Warning window: strictly positive and no more than WARN_SEC seconds left.
  function automatic logic warn_for(input logic [7:0] s);
    return (s != 8'd0) && (int'(s) <= WARN_SEC);
  endfunction

  assign sec_dec  = sat_dec(seconds_left);
  assign sec_done = (prescaler == PRE_MAX) && !pause;

  // Round / time-out state machine; every output is a register of this block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      prescaler    <= '0;
      seconds_left <= '0;
      timer        <= 1'b0;
      warn         <= 1'b0;
      tick         <= 1'b0;
      return_title <= 1'b0;
    end else begin
      tick         <= 1'b0;
      return_title <= 1'b0;
      // A start request restarts from anywhere; LOAD itself always moves on.
      if (wait_for_start && (state != LOAD)) begin
        state        <= LOAD;
        seconds_left <= ROUND_LD;
        prescaler    <= '0;
        timer        <= 1'b0;
        warn         <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            seconds_left <= '0;
            timer        <= 1'b0;
            warn         <= 1'b0;
          end
          LOAD: begin
            state        <= RUN;
            seconds_left <= ROUND_LD;
            prescaler    <= '0;
            warn         <= warn_for(ROUND_LD);
          end
          RUN: begin
            // Abort takes precedence over a second boundary on the same edge.
            if (!game_on) begin
              state        <= IDLE;
              seconds_left <= '0;
              prescaler    <= '0;
              warn         <= 1'b0;
            end else if (sec_done) begin
              prescaler    <= '0;
              tick         <= 1'b1;
              seconds_left <= sec_dec;
              if (sec_dec == 8'd0) begin
                state <= EXPIRED;
                timer <= 1'b1;
                warn  <= 1'b0;
              end else begin
                warn  <= warn_for(sec_dec);
              end
            end else if (!pause) begin
              prescaler <= prescaler + PW'(1);
            end
          end
          EXPIRED: begin
            timer <= 1'b1;
            if (time_out) begin
              state        <= RET_WAIT;
              timer        <= 1'b0;
              seconds_left <= RETURN_LD;
              prescaler    <= '0;
            end
          end
          RET_WAIT: begin
            // Leaving time-out early means the player restarted via START.
            if (!time_out) begin
              state        <= IDLE;
              seconds_left <= '0;
              prescaler    <= '0;
            end else if (sec_done) begin
              prescaler    <= '0;
              tick         <= 1'b1;
              seconds_left <= sec_dec;
              if (sec_dec == 8'd0) begin
                state        <= IDLE;
                return_title <= 1'b1;
              end
            end else if (!pause) begin
              prescaler <= prescaler + PW'(1);
            end
          end
          default: begin
            state        <= IDLE;
            seconds_left <= '0;
            prescaler    <= '0;
            timer        <= 1'b0;
            warn         <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
